dmem_responder: RTL

Memory-side responder for the CPU data port: accepts load/store requests from a pipeline's MEM stage over a valid/ready channel, services them from a byte-addressed little-endian store after a fixed, parameterised latency, and returns read data or store completion over a second valid/ready channel. It replaces the zero-latency data memory model so the pipeline can be exercised against realistic wait states. Non-blocking ordering is not supported: exactly one request is in flight at a time.

---
 rtl/dmem_responder.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding load/store responder for the CPU data
// port. Requests are latched in IDLE, held for LATENCY edges, serviced from a
// byte-addressed little-endian store, then presented until rsp_ready.
// Optional build macro: DMEM_RESP_ERRCHK_EN enables alignment/range checking;
// without it, addresses wrap modulo DEPTH_BYTES and are aligned down to size.
module dmem_responder #(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [3:0]  req_size,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_BYTES);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [63:0]     addr_q, addr_d;
  logic [63:0]     wdata_q, wdata_d;
  logic [3:0]      size_q, size_d;
  logic [63:0]     rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [7:0]      mem_q [DEPTH_BYTES];

  logic            accept;
  logic            access;
  logic [7:0]      bmask;
  logic            size_ok;
  logic [AW-1:0]   eff;
  logic            req_err;
  logic [63:0]     load_data;

  assign accept = (state_q == IDLE) && req_valid;
  assign access = (state_q == WAIT) && (cnt_q == '0);

  // Byte-lane mask for the latched size; empty for illegal sizes
  always_comb begin
    bmask = '0;
    case (size_q)
      4'd1:    bmask = 8'h01;
      4'd2:    bmask = 8'h03;
      4'd4:    bmask = 8'h0F;
      4'd8:    bmask = 8'hFF;
      default: bmask = '0;
    endcase
  end

  assign size_ok = |bmask;

  // Effective byte address: low AW bits, aligned down to the transfer size.
  // With checking enabled, any address reaching the store is already aligned
  // and in range, so the same expression serves both builds.
  assign eff = addr_q[AW-1:0] & ~(AW'(size_q) - AW'(1));

`ifdef DMEM_RESP_ERRCHK_EN
  assign req_err = !size_ok
                || ((addr_q[3:0] & (size_q - 4'd1)) != 4'd0)
                || (({1'b0, addr_q} + 65'(size_q)) > 65'(DEPTH_BYTES));
`else
  assign req_err = !size_ok;
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_q[63:AW];
`endif

  // Assemble load data from the addressed bytes, zero-extended
  always_comb begin
    load_data = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (bmask[i]) begin
        load_data[8*i +: 8] = mem_q[eff + AW'(i)];
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid)      state_d = WAIT;
      WAIT:    if (cnt_q == '0)    state_d = RESP;
      RESP:    if (rsp_ready)      state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // Outputs: handshake flags from state only, data from registers
  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    rsp_rdata = rdata_q;
    rsp_err   = err_q;
  end

  // Datapath next values: request latch, latency counter, response regs
  always_comb begin
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept) begin
      we_d    = req_we;
      addr_d  = req_addr;
      wdata_d = req_wdata;
      size_d  = req_size;
      cnt_d   = CW'(LATENCY - 1);
    end
    if ((state_q == WAIT) && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
    if (access) begin
      err_d   = req_err;
      rdata_d = (req_err || we_q) ? '0 : load_data;
    end
    if ((state_q == RESP) && rsp_ready) begin
      rdata_d = '0;
      err_d   = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage write on the access edge of an error-free store; never reset
  always_ff @(posedge clk) begin
    if (access && we_q && !req_err) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (bmask[i]) begin
          mem_q[eff + AW'(i)] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

endmodule
